sts_autocorrelator: RTL

STS_AUTOCORRELATOR -- requirements
Module: sts_autocorrelator

---
 rtl/sts_autocorrelator_pkg.sv | 57 +++++
 rtl/sts_autocorrelator_cmplx_mult_conj.sv | 28 ++
 rtl/sts_autocorrelator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sts_autocorrelator_pkg.sv
// Shared widths, complex bundles and magnitude helper for the STS autocorrelator.
// Define STS_MAG_MAXMIN_EN to switch |c| to max + min/2.
package sts_autocorrelator_pkg;

  localparam int LAG_DEF = 16;
  localparam int WIN_DEF = 16;
  localparam int SMP_W   = 8;
  localparam int PROD_W  = 17;
  localparam int ACC_W   = 21;
  localparam int OUT_W   = 22;
  localparam int FRAC_W  = 14;

  typedef struct packed {
    logic signed [SMP_W-1:0] re;
    logic signed [SMP_W-1:0] im;
  } smp_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] re;
    logic signed [PROD_W-1:0] im;
  } prod_t;

  typedef struct packed {
    logic signed [ACC_W-1:0] re;
    logic signed [ACC_W-1:0] im;
  } acc_t;

  function automatic logic [OUT_W-1:0] abs_ext(
    input logic signed [ACC_W-1:0] x
  );
    logic signed [OUT_W-1:0] s;
    s = OUT_W'(x);
    return s[OUT_W-1] ? OUT_W'(-s) : OUT_W'(s);
  endfunction

  function automatic logic [OUT_W-1:0] sts_mag(
    input logic signed [ACC_W-1:0] re,
    input logic signed [ACC_W-1:0] im
  );
    logic [OUT_W-1:0] ar;
    logic [OUT_W-1:0] ai;
`ifdef STS_MAG_MAXMIN_EN
    logic [OUT_W-1:0] mx;
    logic [OUT_W-1:0] mn;
`endif
    ar = abs_ext(re);
    ai = abs_ext(im);
`ifdef STS_MAG_MAXMIN_EN
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    return mx + (mn >> 1);
`else
    return ar + ai;
`endif
  endfunction

endpackage

// File: rtl/sts_autocorrelator_cmplx_mult_conj.sv
// Combinational a * conj(b) for Q1.7 samples; Q2.14 result.
// Registered by the parent pipeline stage.
module cmplx_mult_conj
  import sts_autocorrelator_pkg::*;
(
  input  logic signed [SMP_W-1:0]  a_re,
  input  logic signed [SMP_W-1:0]  a_im,
  input  logic signed [SMP_W-1:0]  b_re,
  input  logic signed [SMP_W-1:0]  b_im,
  output logic signed [PROD_W-1:0] p_re,
  output logic signed [PROD_W-1:0] p_im
);

  logic signed [PROD_W-1:0] ar;
  logic signed [PROD_W-1:0] ai;
  logic signed [PROD_W-1:0] br;
  logic signed [PROD_W-1:0] bi;

  assign ar = PROD_W'(a_re);
  assign ai = PROD_W'(a_im);
  assign br = PROD_W'(b_re);
  assign bi = PROD_W'(b_im);

  // (-1)*(-1) + (-1)*(-1) = 2.0 is the only value needing bit 16
  assign p_re = ar * br + ai * bi;
  assign p_im = ai * br - ar * bi;

endmodule

// File: rtl/sts_autocorrelator.sv
// 4-stage lag autocorrelator: delay, conj multiply, moving sum, magnitude.
// STS_MAG_MAXMIN_EN selects the max + min/2 magnitude estimate.
module sts_autocorrelator
  import sts_autocorrelator_pkg::*;
#(
  parameter int LAG = LAG_DEF,
  parameter int WIN = WIN_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             DataInEnable,
  input  logic [SMP_W-1:0] DataInRe,
  input  logic [SMP_W-1:0] DataInIm,
  output logic             DataOutEnable,
  output logic [OUT_W-1:0] AbsoluteData
);

  smp_t  line_q [LAG+1];
  smp_t  line_d [LAG+1];
  logic  v1_q, v1_d;

  prod_t p_q, p_d;
  logic  v2_q, v2_d;

  prod_t pdl_q [WIN];
  prod_t pdl_d [WIN];
  acc_t  acc_q, acc_d;
  logic  v3_q, v3_d;

  logic [OUT_W-1:0] mag_q, mag_d;
  logic             v4_q, v4_d;

  logic signed [PROD_W-1:0] m_re;
  logic signed [PROD_W-1:0] m_im;

  // line[0] is r(n), line[LAG] is r(n-LAG)
  always_comb begin
    v1_d = DataInEnable;
    for (int i = 0; i <= LAG; i++) begin
      line_d[i] = '0;
    end
    if (DataInEnable) begin
      line_d[0].re = $signed(DataInRe);
      line_d[0].im = $signed(DataInIm);
      for (int i = 1; i <= LAG; i++) begin
        line_d[i] = line_q[i-1];
      end
    end
  end

  cmplx_mult_conj u_mult (
    .a_re (line_q[0].re),
    .a_im (line_q[0].im),
    .b_re (line_q[LAG].re),
    .b_im (line_q[LAG].im),
    .p_re (m_re),
    .p_im (m_im)
  );

  always_comb begin
    v2_d = v1_q;
    p_d  = '0;
    if (v1_q) begin
      p_d.re = m_re;
      p_d.im = m_im;
    end
  end

  // pdl_q[WIN-1] holds p(n-WIN) while p_q holds p(n)
  always_comb begin
    v3_d  = v2_q;
    acc_d = '0;
    for (int i = 0; i < WIN; i++) begin
      pdl_d[i] = '0;
    end
    if (v2_q) begin
      pdl_d[0] = p_q;
      for (int i = 1; i < WIN; i++) begin
        pdl_d[i] = pdl_q[i-1];
      end
      acc_d.re = acc_q.re
               + ACC_W'($signed(p_q.re))
               - ACC_W'($signed(pdl_q[WIN-1].re));
      acc_d.im = acc_q.im
               + ACC_W'($signed(p_q.im))
               - ACC_W'($signed(pdl_q[WIN-1].im));
    end
  end

  always_comb begin
    v4_d  = v3_q;
    mag_d = '0;
    if (v3_q) begin
      mag_d = sts_mag(acc_q.re, acc_q.im);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      line_q <= '{default: '0};
      v1_q   <= 1'b0;
      p_q    <= '0;
      v2_q   <= 1'b0;
      pdl_q  <= '{default: '0};
      acc_q  <= '0;
      v3_q   <= 1'b0;
      mag_q  <= '0;
      v4_q   <= 1'b0;
    end else begin
      line_q <= line_d;
      v1_q   <= v1_d;
      p_q    <= p_d;
      v2_q   <= v2_d;
      pdl_q  <= pdl_d;
      acc_q  <= acc_d;
      v3_q   <= v3_d;
      mag_q  <= mag_d;
      v4_q   <= v4_d;
    end
  end

  assign DataOutEnable = v4_q;
  assign AbsoluteData  = mag_q;

endmodule
